// File: rtl/instr_decode_queue_pkg.sv
// Shared types and constants for the TPU instruction front end:
// instruction width, opcode and MAC_op encodings, and the decoded
// register bundle handed to the control FSM.
package instr_decode_queue_pkg;

   localparam int INSTR_SIZE = 64;

   localparam logic [3:0] OP_NOP          = 4'b0000;
   localparam logic [3:0] OP_MATMUL       = 4'b0001;
   localparam logic [3:0] OP_LOAD_WEIGHTS = 4'b0010;

   localparam logic [2:0] MAC_NOP          = 3'b000;
   localparam logic [2:0] MAC_LOAD_WEIGHTS = 3'b001;
   localparam logic [2:0] MAC_MATMUL       = 3'b010;

   typedef struct packed {
      logic [2:0]  MAC_op;
      logic [7:0]  V_dim;
      logic [7:0]  U_dim;
      logic [7:0]  ITER_dim;
      logic [7:0]  V_dim1;
      logic [7:0]  U_dim1;
      logic [7:0]  ITER_dim1;
      logic [11:0] unified_buffer_addr_start_rd;
      logic [11:0] unified_buffer_addr_start_wr;
   } decode_registers_t;

   // Loop bounds downstream are stored as dim-1; a zero dim never reaches here legally.
   function automatic logic [7:0] dim_minus1(input logic [7:0] dim);
      return dim - 8'd1;
   endfunction

endpackage

// File: rtl/instr_decode_queue_if.sv
// Handshake bundle between the instruction source / control FSM (master)
// and the decode queue (slave). flush_i exists only when
// INSTR_QUEUE_FLUSH_EN is defined.
interface instr_decode_queue_if
   import instr_decode_queue_pkg::*;
#(
   parameter int INSTR_W = INSTR_SIZE,
   parameter int DEPTH   = 16
);
   localparam int PTR_W = $clog2(DEPTH);

   logic [INSTR_W-1:0] instr_i;
   logic               instr_valid_i;
   logic               instr_ready_o;
   decode_registers_t  decoded_o;
   logic               decoded_valid_o;
   logic               decoded_ready_i;
   logic [PTR_W:0]     count_o;
   logic               full_o;
   logic               empty_o;
   logic               illegal_op_o;
`ifdef INSTR_QUEUE_FLUSH_EN
   logic               flush_i;

   modport master (
      output instr_i, instr_valid_i, decoded_ready_i, flush_i,
      input  instr_ready_o, decoded_o, decoded_valid_o, count_o,
             full_o, empty_o, illegal_op_o
   );

   modport slave (
      input  instr_i, instr_valid_i, decoded_ready_i, flush_i,
      output instr_ready_o, decoded_o, decoded_valid_o, count_o,
             full_o, empty_o, illegal_op_o
   );
`else
   modport master (
      output instr_i, instr_valid_i, decoded_ready_i,
      input  instr_ready_o, decoded_o, decoded_valid_o, count_o,
             full_o, empty_o, illegal_op_o
   );

   modport slave (
      input  instr_i, instr_valid_i, decoded_ready_i,
      output instr_ready_o, decoded_o, decoded_valid_o, count_o,
             full_o, empty_o, illegal_op_o
   );
`endif

endinterface

// File: rtl/instr_decode_queue_decoder.sv
// Purely combinational opcode decode of the staged instruction word.
// legal_o: the word is a valid instruction (NOP included).
// enq_o:   the word produces a queue entry (legal and not NOP).
module instr_decode_queue_decoder
   import instr_decode_queue_pkg::*;
#(
   parameter int INSTR_W = INSTR_SIZE
) (
   input  logic [INSTR_W-1:0] instr_i,
   output decode_registers_t  decoded_o,
   output logic               legal_o,
   output logic               enq_o
);
   logic [3:0]  op_w;
   logic [7:0]  v_w;
   logic [7:0]  u_w;
   logic [7:0]  it_w;
   logic [11:0] rd_w;
   logic [11:0] wr_w;

   assign op_w = instr_i[3:0];
   assign v_w  = instr_i[11:4];
   assign u_w  = instr_i[19:12];
   assign it_w = instr_i[27:20];
   assign rd_w = instr_i[39:28];
   assign wr_w = instr_i[51:40];

   // Bits above the defined fields are reserved and carry no meaning.
   if (INSTR_W > 52) begin : g_reserved
      logic unused_hi;
      assign unused_hi = ^instr_i[INSTR_W-1:52];
   end

   // Field extraction and legality per opcode; unused fields stay zero.
   always_comb begin
      decoded_o        = '0;
      decoded_o.MAC_op = MAC_NOP;
      legal_o          = 1'b0;
      enq_o            = 1'b0;
      case (op_w)
         OP_MATMUL: begin
            decoded_o.MAC_op                       = MAC_MATMUL;
            decoded_o.V_dim                        = v_w;
            decoded_o.U_dim                        = u_w;
            decoded_o.ITER_dim                     = it_w;
            decoded_o.V_dim1                       = dim_minus1(v_w);
            decoded_o.U_dim1                       = dim_minus1(u_w);
            decoded_o.ITER_dim1                    = dim_minus1(it_w);
            decoded_o.unified_buffer_addr_start_rd = rd_w;
            decoded_o.unified_buffer_addr_start_wr = wr_w;
            legal_o = (v_w != 8'd0) && (u_w != 8'd0) && (it_w != 8'd0);
            enq_o   = legal_o;
         end
         OP_LOAD_WEIGHTS: begin
            decoded_o.MAC_op                       = MAC_LOAD_WEIGHTS;
            decoded_o.V_dim                        = v_w;
            decoded_o.U_dim                        = u_w;
            decoded_o.V_dim1                       = dim_minus1(v_w);
            decoded_o.U_dim1                       = dim_minus1(u_w);
            decoded_o.unified_buffer_addr_start_rd = rd_w;
            legal_o = (v_w != 8'd0) && (u_w != 8'd0);
            enq_o   = legal_o;
         end
         OP_NOP: begin
            legal_o = 1'b1;
            enq_o   = 1'b0;
         end
         default: begin
            legal_o = 1'b0;
            enq_o   = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/instr_decode_queue.sv
// Instruction front end: one-word stage register S, combinational decode
// of S, and a DEPTH-entry first-word-fall-through circular FIFO of
// decoded entries. Ready reserves a FIFO slot for the word sitting in S.
// Optional macro INSTR_QUEUE_FLUSH_EN adds a synchronous flush input.
module instr_decode_queue
   import instr_decode_queue_pkg::*;
#(
   parameter int INSTR_W = INSTR_SIZE,
   parameter int DEPTH   = 16
) (
   input logic                 clk_i,
   input logic                 rst_i,
   instr_decode_queue_if.slave bus
);
   localparam int             PTR_W   = $clog2(DEPTH);
   localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);
   localparam logic [PTR_W-1:0] PTR_ONE = {{(PTR_W-1){1'b0}}, 1'b1};
   localparam logic [PTR_W:0]   CNT_ONE = {{PTR_W{1'b0}}, 1'b1};

   logic [INSTR_W-1:0] stage_q;
   logic               stage_vld_q, stage_vld_d;
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]     count_q, count_d;
   logic               illegal_q, illegal_d;
   decode_registers_t  mem_q [DEPTH];

   decode_registers_t  dec_w;
   logic               legal_w;
   logic               enq_w;
   logic               flush_w;
   logic               ready_w;
   logic               accept_w;
   logic               wr_en_w;
   logic               pop_w;

`ifdef INSTR_QUEUE_FLUSH_EN
   assign flush_w = bus.flush_i;
`else
   assign flush_w = 1'b0;
`endif

   instr_decode_queue_decoder #(.INSTR_W(INSTR_W)) u_decoder (
      .instr_i   (stage_q),
      .decoded_o (dec_w),
      .legal_o   (legal_w),
      .enq_o     (enq_w)
   );

   // Ready depends only on registered state (plus flush), never on decoded_ready_i.
   assign ready_w  = ((count_q + {{PTR_W{1'b0}}, stage_vld_q}) < DEPTH_C) && !flush_w;
   assign accept_w = bus.instr_valid_i && ready_w;
   assign wr_en_w  = stage_vld_q && enq_w && !flush_w;
   assign pop_w    = (count_q != '0) && bus.decoded_ready_i && !flush_w;
   assign illegal_d = stage_vld_q && !legal_w && !flush_w;

   // Next-state for stage valid, pointers and occupancy; flush overrides everything.
   always_comb begin
      stage_vld_d = accept_w;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      if (wr_en_w) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop_w)   rd_ptr_d = rd_ptr_q + PTR_ONE;
      case ({wr_en_w, pop_w})
         2'b10:   count_d = count_q + CNT_ONE;
         2'b01:   count_d = count_q - CNT_ONE;
         default: count_d = count_q;
      endcase
      if (flush_w) begin
         stage_vld_d = 1'b0;
         wr_ptr_d    = '0;
         rd_ptr_d    = '0;
         count_d     = '0;
      end
   end

   // Control state register with asynchronous reset.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         stage_vld_q <= 1'b0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         illegal_q   <= 1'b0;
      end else begin
         stage_vld_q <= stage_vld_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         illegal_q   <= illegal_d;
      end
   end

   // Stage register S captures the raw word on accept; data path is not reset.
   always_ff @(posedge clk_i) begin
      if (accept_w) stage_q <= bus.instr_i;
   end

   // FIFO storage write of the decoded entry; not reset.
   always_ff @(posedge clk_i) begin
      if (wr_en_w) mem_q[wr_ptr_q] <= dec_w;
   end

   assign bus.instr_ready_o   = ready_w;
   assign bus.decoded_valid_o = (count_q != '0);
   assign bus.decoded_o       = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
   assign bus.count_o         = count_q;
   assign bus.full_o          = (count_q == DEPTH_C);
   assign bus.empty_o         = (count_q == '0);
   assign bus.illegal_op_o    = illegal_q;

endmodule

// File: tb/tb_instr_decode_queue.sv
// Directed bench for instr_decode_queue: decode vector table plus
// hand-written fill/drain, illegal, streaming, reset and (with
// INSTR_QUEUE_FLUSH_EN) flush sequences.
module tb_instr_decode_queue;
   import instr_decode_queue_pkg::*;

   localparam int INSTR_W = 64;
   localparam int DEPTH   = 16;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_chk  = 0;
   int   n_fail = 0;
   int   k      = 0;
   decode_registers_t sb_q[$];

   typedef struct {
      logic [63:0]       instr;
      logic              enq;
      logic              ill;
      decode_registers_t d;
   } vec_t;

   vec_t vecs [11];

   always #5 clk = ~clk;

   instr_decode_queue_if #(.INSTR_W(INSTR_W), .DEPTH(DEPTH)) bus ();

   instr_decode_queue #(.INSTR_W(INSTR_W), .DEPTH(DEPTH)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   // A write into a full FIFO must never happen.
   always @(posedge clk) begin
      if (!rst && dut.wr_en_w && (int'(bus.count_o) == DEPTH)) begin
         n_fail++;
         $display("FAIL overflow_write: write with count_o=%0d, required < %0d", bus.count_o, DEPTH);
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [63:0] mk(input logic [3:0] op, input logic [7:0] v, input logic [7:0] u,
                                      input logic [7:0] it, input logic [11:0] rd, input logic [11:0] wr,
                                      input logic [11:0] hi);
      return {hi, wr, rd, it, u, v, op};
   endfunction

   function automatic decode_registers_t dr(input logic [2:0] mac, input logic [7:0] v, input logic [7:0] u,
                                            input logic [7:0] it, input logic [7:0] v1, input logic [7:0] u1,
                                            input logic [7:0] it1, input logic [11:0] rd, input logic [11:0] wr);
      decode_registers_t r;
      r.MAC_op = mac;  r.V_dim = v;  r.U_dim = u;  r.ITER_dim = it;
      r.V_dim1 = v1;   r.U_dim1 = u1; r.ITER_dim1 = it1;
      r.unified_buffer_addr_start_rd = rd;
      r.unified_buffer_addr_start_wr = wr;
      return r;
   endfunction

   function automatic vec_t mkv(input logic [63:0] instr, input logic enq, input logic ill,
                                input decode_registers_t d);
      vec_t t;
      t.instr = instr; t.enq = enq; t.ill = ill; t.d = d;
      return t;
   endfunction

   // Sequence instruction number kk: MATMUL V=kk+1, U=kk+2, ITER=kk%7+1, rd=3kk, wr=5kk+1.
   function automatic logic [63:0] mm_instr(input int kk);
      return mk(4'h1, 8'(kk + 1), 8'(kk + 2), 8'((kk % 7) + 1), 12'(kk * 3), 12'(kk * 5 + 1), 12'h000);
   endfunction

   function automatic decode_registers_t mm_exp(input int kk);
      return dr(3'b010, 8'(kk + 1), 8'(kk + 2), 8'((kk % 7) + 1), 8'(kk), 8'(kk + 1), 8'(kk % 7),
                12'(kk * 3), 12'(kk * 5 + 1));
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Push sequence instructions back-to-back until ready drops.
   task automatic fill();
      int acc = 0;
      for (int c = 0; c < 40; c++) begin
         if (!bus.instr_ready_o) break;
         bus.instr_i       = mm_instr(k);
         bus.instr_valid_i = 1'b1;
         step();
         sb_q.push_back(mm_exp(k));
         k++;
         acc++;
      end
      bus.instr_valid_i = 1'b0;
      chk("fill_accepts", 128'(acc), 128'(DEPTH));
   endtask

   // Pop everything, comparing each head against the scoreboard.
   task automatic drain(input string tag);
      int popped = 0;
      bus.decoded_ready_i = 1'b1;
      for (int c = 0; c < 40; c++) begin
         if (!bus.decoded_valid_o) break;
         if (sb_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s_extra: got unexpected entry 0x%0h, expected none", tag, bus.decoded_o);
            break;
         end
         chk($sformatf("%s_order%0d", tag, popped), 128'(bus.decoded_o), 128'(sb_q.pop_front()));
         step();
         popped++;
      end
      bus.decoded_ready_i = 1'b0;
      chk({tag, "_sb_left"}, 128'(sb_q.size()), 128'(0));
      chk({tag, "_empty_o"}, 128'(bus.empty_o), 128'(1));
   endtask

   initial begin
      int exp_cnt [10];
      int exp_rdy [10];
      logic r;

      bus.instr_i         = '0;
      bus.instr_valid_i   = 1'b0;
      bus.decoded_ready_i = 1'b0;
`ifdef INSTR_QUEUE_FLUSH_EN
      bus.flush_i         = 1'b0;
`endif

      vecs[0]  = mkv(mk(4'h1, 8'd4, 8'd8, 8'd3, 12'h010, 12'h200, 12'h000), 1'b1, 1'b0,
                     dr(3'b010, 8'd4, 8'd8, 8'd3, 8'd3, 8'd7, 8'd2, 12'h010, 12'h200));
      vecs[1]  = mkv(mk(4'h2, 8'd16, 8'd1, 8'h55, 12'hABC, 12'h123, 12'h000), 1'b1, 1'b0,
                     dr(3'b001, 8'd16, 8'd1, 8'd0, 8'd15, 8'd0, 8'd0, 12'hABC, 12'h000));
      vecs[2]  = mkv(mk(4'h1, 8'd255, 8'd255, 8'd255, 12'hFFF, 12'hFFF, 12'hFFF), 1'b1, 1'b0,
                     dr(3'b010, 8'd255, 8'd255, 8'd255, 8'd254, 8'd254, 8'd254, 12'hFFF, 12'hFFF));
      vecs[3]  = mkv(mk(4'h1, 8'd1, 8'd1, 8'd1, 12'h001, 12'h002, 12'h000), 1'b1, 1'b0,
                     dr(3'b010, 8'd1, 8'd1, 8'd1, 8'd0, 8'd0, 8'd0, 12'h001, 12'h002));
      vecs[4]  = mkv(mk(4'hF, 8'd4, 8'd8, 8'd3, 12'h010, 12'h200, 12'h000), 1'b0, 1'b1, '0);
      vecs[5]  = mkv(mk(4'h1, 8'd4, 8'd0, 8'd3, 12'h010, 12'h200, 12'h000), 1'b0, 1'b1, '0);
      vecs[6]  = mkv(mk(4'h1, 8'd4, 8'd8, 8'd0, 12'h010, 12'h200, 12'h000), 1'b0, 1'b1, '0);
      vecs[7]  = mkv(mk(4'h2, 8'd0, 8'd5, 8'd0, 12'h100, 12'h000, 12'h000), 1'b0, 1'b1, '0);
      vecs[8]  = mkv(mk(4'h0, 8'd4, 8'd8, 8'd3, 12'h010, 12'h200, 12'h000), 1'b0, 1'b0, '0);
      vecs[9]  = mkv(mk(4'h3, 8'd4, 8'd8, 8'd3, 12'h010, 12'h200, 12'h000), 1'b0, 1'b1, '0);
      vecs[10] = mkv(mk(4'h2, 8'd200, 8'd100, 8'd0, 12'h7FF, 12'h000, 12'h000), 1'b1, 1'b0,
                     dr(3'b001, 8'd200, 8'd100, 8'd0, 8'd199, 8'd99, 8'd0, 12'h7FF, 12'h000));

      // ---- reset state ----
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      step();
      chk("rst_empty",    128'(bus.empty_o),         128'(1));
      chk("rst_full",     128'(bus.full_o),          128'(0));
      chk("rst_count",    128'(bus.count_o),         128'(0));
      chk("rst_dvalid",   128'(bus.decoded_valid_o), 128'(0));
      chk("rst_decoded",  128'(bus.decoded_o),       128'(0));
      chk("rst_illegal",  128'(bus.illegal_op_o),    128'(0));
      chk("rst_ready",    128'(bus.instr_ready_o),   128'(1));

      // ---- decode vector table: one instruction at a time from empty ----
      for (int i = 0; i < 11; i++) begin
         bus.instr_i       = vecs[i].instr;
         bus.instr_valid_i = 1'b1;
         step();
         bus.instr_valid_i = 1'b0;
         chk($sformatf("vec%0d_dvalid_N", i),  128'(bus.decoded_valid_o), 128'(0));
         chk($sformatf("vec%0d_illegal_N", i), 128'(bus.illegal_op_o),    128'(0));
         step();
         chk($sformatf("vec%0d_dvalid", i),  128'(bus.decoded_valid_o), 128'(vecs[i].enq));
         chk($sformatf("vec%0d_illegal", i), 128'(bus.illegal_op_o),    128'(vecs[i].ill));
         chk($sformatf("vec%0d_count", i),   128'(bus.count_o),         128'(vecs[i].enq));
         chk($sformatf("vec%0d_decoded", i), 128'(bus.decoded_o),
             vecs[i].enq ? 128'(vecs[i].d) : 128'(0));
         bus.decoded_ready_i = 1'b1;
         step();
         bus.decoded_ready_i = 1'b0;
         chk($sformatf("vec%0d_pulse_end", i), 128'(bus.illegal_op_o), 128'(0));
         chk($sformatf("vec%0d_empty", i),     128'(bus.empty_o),      128'(1));
      end

      // ---- fill to full with pointers offset, then drain across the wrap ----
      fill();
      chk("fill_ready_low", 128'(bus.instr_ready_o), 128'(0));
      chk("fill_count15",   128'(bus.count_o),       128'(15));
      step();
      chk("full_count",   128'(bus.count_o),       128'(16));
      chk("full_flag",    128'(bus.full_o),        128'(1));
      chk("full_ready",   128'(bus.instr_ready_o), 128'(0));
      chk("full_empty",   128'(bus.empty_o),       128'(0));
      drain("wrap");

      // ---- pop requests while empty are ignored ----
      bus.decoded_ready_i = 1'b1;
      repeat (3) step();
      bus.decoded_ready_i = 1'b0;
      chk("idle_pop_count", 128'(bus.count_o), 128'(0));
      bus.instr_i       = mm_instr(k);
      bus.instr_valid_i = 1'b1;
      step();
      bus.instr_valid_i = 1'b0;
      sb_q.push_back(mm_exp(k));
      k++;
      step();
      chk("idle_pop_count1", 128'(bus.count_o), 128'(1));
      drain("idle_pop");

      // ---- illegal 0xF, MATMUL U=0, NOP back to back ----
      bus.instr_valid_i = 1'b1;
      bus.instr_i = mk(4'hF, 8'd4, 8'd8, 8'd3, 12'h010, 12'h200, 12'h000);
      step();
      chk("ill_seq_e1", 128'(bus.illegal_op_o), 128'(0));
      bus.instr_i = mk(4'h1, 8'd4, 8'd0, 8'd3, 12'h010, 12'h200, 12'h000);
      step();
      chk("ill_seq_e2", 128'(bus.illegal_op_o), 128'(1));
      bus.instr_i = mk(4'h0, 8'd0, 8'd0, 8'd0, 12'h000, 12'h000, 12'h000);
      step();
      chk("ill_seq_e3", 128'(bus.illegal_op_o), 128'(1));
      bus.instr_valid_i = 1'b0;
      step();
      chk("ill_seq_e4_nop", 128'(bus.illegal_op_o), 128'(0));
      step();
      chk("ill_seq_e5", 128'(bus.illegal_op_o), 128'(0));
      chk("ill_seq_count", 128'(bus.count_o), 128'(0));

      // ---- full FIFO with simultaneous push and pop ----
      fill();
      step();
      chk("stream_start_count", 128'(bus.count_o), 128'(16));
      exp_cnt = '{15, 14, 14, 14, 14, 14, 14, 14, 14, 14};
      exp_rdy = '{0, 1, 1, 1, 1, 1, 1, 1, 1, 1};
      bus.decoded_ready_i = 1'b1;
      for (int c = 0; c < 10; c++) begin
         r = bus.instr_ready_o;
         chk($sformatf("stream_rdy%0d", c), 128'(r), 128'(exp_rdy[c]));
         if (sb_q.size() != 0) chk($sformatf("stream_head%0d", c), 128'(bus.decoded_o), 128'(sb_q[0]));
         bus.instr_i       = mm_instr(k);
         bus.instr_valid_i = r;
         step();
         if (sb_q.size() != 0) void'(sb_q.pop_front());
         if (r) begin
            sb_q.push_back(mm_exp(k));
            k++;
         end
         chk($sformatf("stream_count%0d", c), 128'(bus.count_o), 128'(exp_cnt[c]));
      end
      bus.instr_valid_i   = 1'b0;
      bus.decoded_ready_i = 1'b0;
      step();
      drain("stream");

      // ---- asynchronous reset mid-operation ----
      bus.instr_valid_i = 1'b1;
      for (int c = 0; c < 3; c++) begin
         bus.instr_i = mm_instr(k + c);
         step();
      end
      bus.instr_valid_i = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      chk("arst_count",  128'(bus.count_o),         128'(0));
      chk("arst_empty",  128'(bus.empty_o),         128'(1));
      chk("arst_dvalid", 128'(bus.decoded_valid_o), 128'(0));
      chk("arst_ready",  128'(bus.instr_ready_o),   128'(1));
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      step();
      step();
      chk("arst_after_count",   128'(bus.count_o),      128'(0));
      chk("arst_after_illegal", 128'(bus.illegal_op_o), 128'(0));
      k += 3;

`ifdef INSTR_QUEUE_FLUSH_EN
      // ---- flush with 5 queued and one in flight ----
      bus.instr_valid_i = 1'b1;
      for (int c = 0; c < 6; c++) begin
         bus.instr_i = mm_instr(k + c);
         step();
      end
      chk("flush_pre_count", 128'(bus.count_o), 128'(5));
      bus.instr_i = mm_instr(k + 6);
      bus.flush_i = 1'b1;
      #1;
      chk("flush_ready_low", 128'(bus.instr_ready_o), 128'(0));
      step();
      bus.flush_i       = 1'b0;
      bus.instr_valid_i = 1'b0;
      chk("flush_count",   128'(bus.count_o),         128'(0));
      chk("flush_empty",   128'(bus.empty_o),         128'(1));
      chk("flush_dvalid",  128'(bus.decoded_valid_o), 128'(0));
      chk("flush_illegal", 128'(bus.illegal_op_o),    128'(0));
      step();
      chk("flush_inflight_dropped", 128'(bus.count_o), 128'(0));
      k += 7;
      bus.instr_i       = mm_instr(k);
      bus.instr_valid_i = 1'b1;
      step();
      bus.instr_valid_i = 1'b0;
      sb_q.push_back(mm_exp(k));
      k++;
      step();
      drain("post_flush");
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
